// File: rtl/rv32_cache_pkg.sv
// Shared cache types and helpers: FSM encoding, address field offsets
// and the store byte-merge function.
package rv32_cache_pkg;

  localparam int SET_LOG_DEF  = 6;
  localparam int WORD_LOG_DEF = 3;
  localparam int WORD_OFF     = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WB     = 2'd1,
    ST_REFILL = 2'd2
  } dc_state_e;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Line storage: data array (async read, byte-enabled store port,
// refill port) plus tag/valid/dirty arrays. Valid/dirty are reset.
module dcache_line_store
  import rv32_cache_pkg::*;
#(
  parameter int SET_LOG  = SET_LOG_DEF,
  parameter int WORD_LOG = WORD_LOG_DEF,
  parameter int TAG_W    = 32 - SET_LOG - WORD_LOG - 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SET_LOG-1:0]  rd_set_i,
  input  logic [WORD_LOG-1:0] rd_word_i,
  output logic [31:0]         rd_data_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic                rd_valid_o,
  output logic                rd_dirty_o,
  input  logic [SET_LOG-1:0]  wb_set_i,
  input  logic [WORD_LOG-1:0] wb_word_i,
  output logic [31:0]         wb_data_o,
  input  logic                st_en_i,
  input  logic [3:0]          st_be_i,
  input  logic [31:0]         st_wd_i,
  input  logic                rf_en_i,
  input  logic [SET_LOG-1:0]  rf_set_i,
  input  logic [WORD_LOG-1:0] rf_word_i,
  input  logic [31:0]         rf_data_i,
  input  logic                fill_i,
  input  logic [TAG_W-1:0]    fill_tag_i
);

  localparam int SETS = 1 << SET_LOG;
  localparam int LINES_W = SETS << WORD_LOG;

  logic [31:0]      data_q [LINES_W];
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  dirty_q;

  assign rd_data_o  = data_q[{rd_set_i, rd_word_i}];
  assign rd_tag_o   = tag_q[rd_set_i];
  assign rd_valid_o = valid_q[rd_set_i];
  assign rd_dirty_o = dirty_q[rd_set_i];
  assign wb_data_o  = data_q[{wb_set_i, wb_word_i}];

  // Data writes: store-hit byte merge or refill beat (never both).
  always_ff @(posedge clk) begin
    if (st_en_i) begin
      data_q[{rd_set_i, rd_word_i}] <=
        byte_merge(rd_data_o, st_wd_i, st_be_i);
    end else if (rf_en_i) begin
      data_q[{rf_set_i, rf_word_i}] <= rf_data_i;
    end
  end

  // Tag is installed when the refill completes.
  always_ff @(posedge clk) begin
    if (fill_i) tag_q[rf_set_i] <= fill_tag_i;
  end

  // Valid/dirty: fill makes line clean+valid, store hit dirties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_i) begin
      valid_q[rf_set_i] <= 1'b1;
      dirty_q[rf_set_i] <= 1'b0;
    end else if (st_en_i) begin
      dirty_q[rd_set_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/rv32_dcache.sv
// Direct-mapped write-back/write-allocate data cache with miss FSM.
// Optional DCACHE_STATS_EN adds hit_cnt/miss_cnt outputs.
module rv32_dcache
  import rv32_cache_pkg::*;
#(
  parameter int SET_LOG  = SET_LOG_DEF,
  parameter int WORD_LOG = WORD_LOG_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_rd_req,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        dcache_miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic        mem_ack,
  input  logic [31:0] mem_rd
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int SET_LO = WORD_OFF + WORD_LOG;
  localparam int TAG_LO = SET_LO + SET_LOG;
  localparam int TAG_W  = 32 - TAG_LO;
  localparam logic [WORD_LOG-1:0] LAST = '1;

  logic [WORD_LOG-1:0] a_word;
  logic [SET_LOG-1:0]  a_set;
  logic [TAG_W-1:0]    a_tag;
  logic                req, is_st, hit, st_en;
  logic [31:0]         l_data, wb_data;
  logic [TAG_W-1:0]    l_tag;
  logic                l_valid, l_dirty;
  logic [SET_LOG-1:0]  wb_set;
  logic [WORD_LOG-1:0] wb_word, cnt_nx;
  logic                rf_en, fill;

  dc_state_e           state_q, state_d;
  logic [WORD_LOG-1:0] cnt_q, cnt_d;
  logic [SET_LOG-1:0]  set_q, set_d;
  logic [TAG_W-1:0]    rtag_q, rtag_d, vtag_q, vtag_d;
  logic                mreq_q, mreq_d, mwe_q, mwe_d;
  logic [31:0]         maddr_q, maddr_d, mwd_q, mwd_d;

  logic unused_addr;
  assign unused_addr = &{1'b0, cpu_addr[1:0]};

  assign a_word = cpu_addr[SET_LO-1:WORD_OFF];
  assign a_set  = cpu_addr[TAG_LO-1:SET_LO];
  assign a_tag  = cpu_addr[31:TAG_LO];

  assign req   = cpu_rd_req | (|cpu_we);
  assign is_st = |cpu_we;
  assign hit   = req && l_valid && (l_tag == a_tag) &&
                 (state_q == ST_IDLE);
  assign st_en = hit && is_st;

  assign cpu_rd      = (hit && !is_st) ? l_data : '0;
  assign dcache_miss = req && !hit;

  assign cnt_nx  = cnt_q + 1'b1;
  assign wb_set  = (state_q == ST_IDLE) ? a_set : set_q;
  assign wb_word = (state_q == ST_IDLE) ? '0 : cnt_nx;

  assign mem_req  = mreq_q;
  assign mem_we   = mwe_q;
  assign mem_addr = maddr_q;
  assign mem_wd   = mwd_q;

  dcache_line_store #(
    .SET_LOG (SET_LOG),
    .WORD_LOG(WORD_LOG),
    .TAG_W   (TAG_W)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_set_i  (a_set),
    .rd_word_i (a_word),
    .rd_data_o (l_data),
    .rd_tag_o  (l_tag),
    .rd_valid_o(l_valid),
    .rd_dirty_o(l_dirty),
    .wb_set_i  (wb_set),
    .wb_word_i (wb_word),
    .wb_data_o (wb_data),
    .st_en_i   (st_en),
    .st_be_i   (cpu_we),
    .st_wd_i   (cpu_wd),
    .rf_en_i   (rf_en),
    .rf_set_i  (set_q),
    .rf_word_i (cnt_q),
    .rf_data_i (mem_rd),
    .fill_i    (fill),
    .fill_tag_i(rtag_q)
  );

  // Miss FSM next state and registered memory-side beat outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set_d   = set_q;
    rtag_d  = rtag_q;
    vtag_d  = vtag_q;
    mreq_d  = mreq_q;
    mwe_d   = mwe_q;
    maddr_d = maddr_q;
    mwd_d   = mwd_q;
    rf_en   = 1'b0;
    fill    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (dcache_miss) begin
          set_d  = a_set;
          rtag_d = a_tag;
          vtag_d = l_tag;
          cnt_d  = '0;
          mreq_d = 1'b1;
          if (l_valid && l_dirty) begin
            state_d = ST_WB;
            mwe_d   = 1'b1;
            maddr_d = {l_tag, a_set, {WORD_LOG{1'b0}}, 2'b00};
            mwd_d   = wb_data;
          end else begin
            state_d = ST_REFILL;
            mwe_d   = 1'b0;
            maddr_d = {a_tag, a_set, {WORD_LOG{1'b0}}, 2'b00};
            mwd_d   = '0;
          end
        end
      end
      ST_WB: begin
        if (mem_ack) begin
          if (cnt_q == LAST) begin
            state_d = ST_REFILL;
            cnt_d   = '0;
            mwe_d   = 1'b0;
            maddr_d = {rtag_q, set_q, {WORD_LOG{1'b0}}, 2'b00};
            mwd_d   = '0;
          end else begin
            cnt_d   = cnt_nx;
            maddr_d = {vtag_q, set_q, cnt_nx, 2'b00};
            mwd_d   = wb_data;
          end
        end
      end
      ST_REFILL: begin
        if (mem_ack) begin
          rf_en = 1'b1;
          if (cnt_q == LAST) begin
            fill    = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
            mreq_d  = 1'b0;
            mwe_d   = 1'b0;
            maddr_d = '0;
          end else begin
            cnt_d   = cnt_nx;
            maddr_d = {rtag_q, set_q, cnt_nx, 2'b00};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, latched miss context and memory beat registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      set_q   <= '0;
      rtag_q  <= '0;
      vtag_q  <= '0;
      mreq_q  <= 1'b0;
      mwe_q   <= 1'b0;
      maddr_q <= '0;
      mwd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      set_q   <= set_d;
      rtag_q  <= rtag_d;
      vtag_q  <= vtag_d;
      mreq_q  <= mreq_d;
      mwe_q   <= mwe_d;
      maddr_q <= maddr_d;
      mwd_q   <= mwd_d;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Hit and miss event counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (state_q == ST_IDLE && state_d != ST_IDLE)
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_rv32_dcache.sv
// Scoreboard bench for rv32_dcache: drivers queue expected beats,
// load data and miss lengths; monitors pop and compare.
module tb_rv32_dcache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_rd_req = 1'b0;
  logic [3:0]  cpu_we = '0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wd = '0;
  logic [31:0] cpu_rd;
  logic        dcache_miss;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wd;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rd = '0;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
  logic [31:0] h0, m0;
`endif

  rv32_dcache dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_rd_req (cpu_rd_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wd     (cpu_wd),
    .cpu_rd     (cpu_rd),
    .dcache_miss(dcache_miss),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_ack    (mem_ack),
    .mem_rd     (mem_rd)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } beat_t;

  beat_t       beat_q[$];
  logic [31:0] rd_q[$];
  int          miss_q[$];
  int          total = 0;
  int          bad = 0;
  int          ack_div = 1;
  int          ack_seen = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return 32'h1000 + ((a - 32'h40) >> 2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_refill(input logic [31:0] base);
    for (int i = 0; i < 8; i++)
      beat_q.push_back('{1'b0, base + 32'(4 * i), 32'h0});
  endtask

  // Memory model: ack every ack_div-th cycle of mem_req; checks beats.
  int          wcnt = 0;
  logic        waiting = 1'b0;
  logic [31:0] wa, wwd;
  logic        wwe;
  always @(negedge clk) begin
    if (!rst_n || !mem_req) begin
      mem_ack = 1'b0;
      wcnt = 0;
      waiting = 1'b0;
    end else begin
      if (waiting) begin
        chk("hold_addr", mem_addr, wa);
        chk("hold_wd", mem_wd, wwd);
        chk("hold_we", 32'(mem_we), 32'(wwe));
      end
      wcnt++;
      if (wcnt >= ack_div) begin
        beat_t b;
        mem_ack = 1'b1;
        wcnt = 0;
        waiting = 1'b0;
        mem_rd = mem_we ? 32'h0 : mem_f(mem_addr);
        ack_seen++;
        if (beat_q.size() == 0) begin
          chk("beat_extra", mem_addr, 32'hFFFF_FFFF);
        end else begin
          b = beat_q.pop_front();
          chk("beat_we", 32'(mem_we), 32'(b.we));
          chk("beat_addr", mem_addr, b.addr);
          if (b.we) chk("beat_wd", mem_wd, b.wd);
        end
      end else begin
        mem_ack = 1'b0;
        waiting = 1'b1;
        wa = mem_addr;
        wwd = mem_wd;
        wwe = mem_we;
      end
    end
  end

  // Load-data and miss-length monitor.
  int run = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else begin
      if (cpu_rd_req && cpu_we == 4'h0 && !dcache_miss) begin
        if (rd_q.size() == 0) chk("rd_extra", cpu_rd, 32'hFFFF_FFFF);
        else chk("load_data", cpu_rd, rd_q.pop_front());
      end else begin
        chk("rd_zero", cpu_rd, 32'h0);
      end
      if (dcache_miss) begin
        run++;
      end else if (run > 0) begin
        if (miss_q.size() == 0) chk("miss_extra", 32'(run), 32'h0);
        else chk("miss_len", 32'(run), 32'(miss_q.pop_front()));
        run = 0;
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (dcache_miss && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (dcache_miss) chk("timeout", 32'(dcache_miss), 32'h0);
    @(posedge clk);
    #1;
    cpu_rd_req = 1'b0;
    cpu_we = 4'h0;
  endtask

  task automatic access(input logic [31:0] a, input logic [3:0] we,
                        input logic [31:0] wd);
    @(posedge clk);
    #1;
    cpu_addr = a;
    cpu_we = we;
    cpu_wd = wd;
    cpu_rd_req = (we == 4'h0);
    wait_done();
  endtask

  initial begin
    int n;
    int base;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_miss_idle", 32'(dcache_miss), 32'h0);
    cpu_rd_req = 1'b1;
    #1;
    chk("rst_miss_req", 32'(dcache_miss), 32'h1);
    chk("rst_cpu_rd", cpu_rd, 32'h0);
    cpu_rd_req = 1'b0;
`ifdef DCACHE_STATS_EN
    chk("rst_hit_cnt", hit_cnt, 32'h0);
    chk("rst_miss_cnt", miss_cnt, 32'h0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Cold load miss, then hit in the same line.
    exp_refill(32'h40);
    miss_q.push_back(9);
    rd_q.push_back(32'h1000);
    access(32'h40, 4'h0, 32'h0);
    rd_q.push_back(32'h1001);
    access(32'h44, 4'h0, 32'h0);

    // Store hit with partial byte enables.
    access(32'h48, 4'b0011, 32'hAAAA_BBBB);
    rd_q.push_back(32'h0000_BBBB);
    access(32'h48, 4'h0, 32'h0);

    // Dirty eviction by a same-set, new-tag load.
    for (int i = 0; i < 8; i++)
      beat_q.push_back('{1'b1, 32'h40 + 32'(4 * i),
                         (i == 2) ? 32'h0000_BBBB : 32'h1000 + 32'(i)});
    exp_refill(32'h840);
    miss_q.push_back(17);
    rd_q.push_back(32'h1200);
    access(32'h840, 4'h0, 32'h0);

    // Slow memory: dirty again, ack every third cycle.
    access(32'h844, 4'hF, 32'hDEAD_BEEF);
    ack_div = 3;
    for (int i = 0; i < 8; i++)
      beat_q.push_back('{1'b1, 32'h840 + 32'(4 * i),
                         (i == 1) ? 32'hDEAD_BEEF : 32'h1200 + 32'(i)});
    exp_refill(32'h40);
    miss_q.push_back(49);
    rd_q.push_back(32'h1003);
    access(32'h4C, 4'h0, 32'h0);
    ack_div = 1;

    // Reset in the middle of a refill.
    for (int i = 0; i < 4; i++)
      beat_q.push_back('{1'b0, 32'h1040 + 32'(4 * i), 32'h0});
    exp_refill(32'h1040);
    miss_q.push_back(9);
    rd_q.push_back(32'h1400);
    @(posedge clk);
    #1;
    base = ack_seen;
    cpu_addr = 32'h1040;
    cpu_we = 4'h0;
    cpu_rd_req = 1'b1;
    n = 0;
    while (ack_seen < base + 4 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("rst_beats", 32'(ack_seen - base), 32'h4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(mem_req), 32'h0);
    chk("mid_rst_we", 32'(mem_we), 32'h0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_wd", mem_wd, 32'h0);
    chk("mid_rst_miss", 32'(dcache_miss), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_done();
    rd_q.push_back(32'h1401);
    access(32'h1044, 4'h0, 32'h0);

    // One miss followed by five hits.
`ifdef DCACHE_STATS_EN
    h0 = hit_cnt;
    m0 = miss_cnt;
`endif
    exp_refill(32'h2040);
    miss_q.push_back(9);
    rd_q.push_back(32'h1800);
    access(32'h2040, 4'h0, 32'h0);
    for (int i = 1; i < 5; i++) begin
      rd_q.push_back(32'h1800 + 32'(i));
      access(32'h2040 + 32'(4 * i), 4'h0, 32'h0);
    end
`ifdef DCACHE_STATS_EN
    chk("stat_hits", hit_cnt - h0, 32'd5);
    chk("stat_miss", miss_cnt - m0, 32'd1);
`endif

    repeat (3) @(posedge clk);
    chk("beats_left", 32'(beat_q.size()), 32'h0);
    chk("loads_left", 32'(rd_q.size()), 32'h0);
    chk("misses_left", 32'(miss_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
